inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//   Instruction queue between the L1 instruction cache output pipeline and the decode stage.
//   Stores up to 2**DEPTH_LOG2 fetched instructions with their PC, predicted branch target and trap info.
//   Decouples cache hit/miss latency from decode back-pressure.
//   Drops all contents on a pipeline flush.
// PARAMETERS
//   INT_SIG_WIDTH  1  width of trapno field (same value as the cache's INT_SIG_WIDTH)
//   DEPTH_LOG2     3  log2 of queue depth; DEPTH = 2**DEPTH_LOG2 entries (DEPTH_LOG2 >= 1)
// PORTS
//   clk              in   1              clock; all state updates on posedge
//   rst              in   1              synchronous reset, active-high
//   flush_i          in   1              pipeline flush (also driven high on fence_i)
//   input_valid      in   1              cache_valid from icache
//   queue_ready      out  1              to icache output_ready
//   pc_i             in   32             instruction PC
//   branch_target_i  in   31             predicted target, offset by 1 bit (bit 0 implied 0)
//   inst_i           in   32             instruction word
//   trapno_i         in   INT_SIG_WIDTH  trap number
//   have_trap_i      in   1              entry carries a trap (inst_i is don't-care)
//   output_ready     in   1              decode accepts entry
//   queue_valid      out  1              head entry valid
//   pc_o             out  32             head entry PC
//   branch_target_o  out  31             head entry branch target
//   inst_o           out  32             head entry instruction
//   trapno_o         out  INT_SIG_WIDTH  head entry trap number
//   have_trap_o      out  1              head entry trap flag
//   count_o          out  DEPTH_LOG2+1   current occupancy, 0..DEPTH
// BEHAVIOUR
// - push = input_valid && queue_ready.
// - pop  = queue_valid && output_ready.
// - queue_ready = (count != DEPTH).
// - queue_valid = (count != 0).
// - Neither ready nor valid depends combinationally on the opposite side. There is no
//   input-to-output path.
// - Storage: circular buffer with wptr/rptr of DEPTH_LOG2 bits, each wrapping mod DEPTH.
//   count is DEPTH_LOG2+1 bits.
// - Push writes the entry {pc, branch_target, inst, trapno, have_trap} at wptr, then
//   wptr <= wptr+1.
// - Pop advances rptr <= rptr+1.
// - count update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
// - Push and pop in the same cycle are legal whenever 0 < count < DEPTH.
// - Latency: an entry pushed at edge N is presented on the outputs after edge N
//   (first-word-fall-through from registers; minimum 1 cycle, no bypass when empty).
// - Outputs come from the entry at rptr.
// - When count == 0, pc_o, branch_target_o, inst_o, trapno_o and have_trap_o are forced to 0.
// - Full (count == DEPTH): queue_ready = 0. A pop that cycle frees one slot;
//   queue_ready rises after the edge.
// - Empty (count == 0): queue_valid = 0 and no pop occurs.
// - Flush: at the next edge wptr, rptr and count become 0. A simultaneous push and/or pop
//   is discarded. Priority order: rst > flush_i > push/pop.
// - The entry written during a flush cycle never becomes visible.
// - Reset values: queue_valid = 0, queue_ready = 1 (the cycle after rst deasserts),
//   count_o = 0, all data outputs 0.
// - Storage contents need no reset.
// - Reset asserted mid-stream empties the queue exactly like a flush.
// - An entry with have_trap_i = 1 is stored and forwarded unchanged. The queue never
//   inspects or generates traps.
// - Storage maps to distributed RAM: one write port, asynchronous read at rptr.
// TESTING
// - Reset then idle -> queue_valid=0, queue_ready=1, count_o=0, all data outputs 0.
// - Push pc 0x80000000..0x8000001C (8 entries, DEPTH_LOG2=3), output_ready=0 -> count_o=8,
//   queue_ready=0. Then output_ready=1 -> pcs pop in order, one per cycle.
// - Single push of pc=0x1000 and inst=0x00000013 while empty -> queue_valid=1 on the next
//   cycle with pc_o=0x1000, inst_o=0x13.
// - Continuous push+pop for 20 cycles at count=3 -> count_o stays 3; FIFO order is preserved
//   across pointer wrap.
// - flush_i with count=5 while pushing pc=0x2000 -> next cycle count_o=0, queue_valid=0.
//   pc 0x2000 is never output.
// - Push with have_trap_i=1, trapno_i=1 -> popped with have_trap_o=1, trapno_o=1, PC unchanged.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction queue between the icache output pipeline and decode.
// Circular buffer in distributed RAM with first-word-fall-through head outputs.
module inst_fetch_queue #(
  parameter int INT_SIG_WIDTH = 1,
  parameter int DEPTH_LOG2    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     input_valid,
  output logic                     queue_ready,
  input  logic [31:0]              pc_i,
  input  logic [30:0]              branch_target_i,
  input  logic [31:0]              inst_i,
  input  logic [INT_SIG_WIDTH-1:0] trapno_i,
  input  logic                     have_trap_i,
  input  logic                     output_ready,
  output logic                     queue_valid,
  output logic [31:0]              pc_o,
  output logic [30:0]              branch_target_o,
  output logic [31:0]              inst_o,
  output logic [INT_SIG_WIDTH-1:0] trapno_o,
  output logic                     have_trap_o,
  output logic [DEPTH_LOG2:0]      count_o
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = 32 + 31 + 32 + INT_SIG_WIDTH + 1;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push, pop;
  logic [ENTRY_W-1:0]    head;

  // Handshakes depend only on the registered occupancy, never on the other side.
  assign queue_ready = (count_q != FULL_COUNT);
  assign queue_valid = (count_q != '0);
  assign push        = input_valid && queue_ready;
  assign pop         = queue_valid && output_ready;
  assign count_o     = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush_i && !rst) begin
      mem_q[wptr_q] <= {pc_i, branch_target_i, inst_i, trapno_i, have_trap_i};
    end
  end

  assign head = queue_valid ? mem_q[rptr_q] : '0;
  assign {pc_o, branch_target_o, inst_o, trapno_o, have_trap_o} = head;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue using a scoreboard queue of expected entries.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [30:0] bt;
    logic [31:0] inst;
    logic [0:0]  trapno;
    logic        trap;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        input_valid = 1'b0;
  logic        queue_ready;
  logic [31:0] pc_i = '0;
  logic [30:0] branch_target_i = '0;
  logic [31:0] inst_i = '0;
  logic [0:0]  trapno_i = '0;
  logic        have_trap_i = 1'b0;
  logic        output_ready = 1'b0;
  logic        queue_valid;
  logic [31:0] pc_o;
  logic [30:0] branch_target_o;
  logic [31:0] inst_o;
  logic [0:0]  trapno_o;
  logic        have_trap_o;
  logic [3:0]  count_o;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  inst_fetch_queue #(.INT_SIG_WIDTH(1), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .input_valid(input_valid),
    .queue_ready(queue_ready), .pc_i(pc_i), .branch_target_i(branch_target_i),
    .inst_i(inst_i), .trapno_i(trapno_i), .have_trap_i(have_trap_i),
    .output_ready(output_ready), .queue_valid(queue_valid), .pc_o(pc_o),
    .branch_target_o(branch_target_o), .inst_o(inst_o), .trapno_o(trapno_o),
    .have_trap_o(have_trap_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc     = pc;
    e.bt     = 31'($urandom);
    e.inst   = $urandom;
    e.trapno = 1'b0;
    e.trap   = 1'b0;
    return e;
  endfunction

  // One clock cycle: drive, capture head before the edge, update the scoreboard model.
  task automatic step(input bit psh, input ent_t e, input bit pp, input bit fl,
                      output bit popped, output ent_t exp_e, output ent_t act_e);
    int pre;
    flush_i = fl; input_valid = psh; output_ready = pp;
    pc_i = e.pc; branch_target_i = e.bt; inst_i = e.inst;
    trapno_i = e.trapno; have_trap_i = e.trap;
    #1;
    act_e  = {pc_o, branch_target_o, inst_o, trapno_o, have_trap_o};
    popped = 1'b0;
    exp_e  = '0;
    pre    = sb.size();
    if (fl) begin
      sb.delete();
    end else begin
      if (pp && pre != 0) begin
        popped = 1'b1;
        exp_e  = sb.pop_front();
      end
      if (psh && pre != DEPTH) sb.push_back(e);
    end
    @(posedge clk);
    #1;
    flush_i = 1'b0; input_valid = 1'b0; output_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (queue_valid !== 1'b0 || queue_ready !== 1'b1 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b ready=%b count=%0d, required 0/1/0", queue_valid, queue_ready, count_o);
    end
    checks++;
    if ({pc_o, branch_target_o, inst_o, trapno_o, have_trap_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: pc=%h bt=%h inst=%h, required all zero", pc_o, branch_target_o, inst_o);
    end
    $display("reset: valid=%b ready=%b count=%0d", queue_valid, queue_ready, count_o);
  endtask

  task automatic test_fill_drain;
    bit popped; ent_t ex, ac;
    for (int i = 0; i < DEPTH; i++) step(1, mk(32'h8000_0000 + 32'(4 * i)), 0, 0, popped, ex, ac);
    checks++;
    if (count_o !== 4'd8 || queue_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: count=%0d ready=%b, required 8/0", count_o, queue_ready);
    end
    // Push while full must be dropped.
    step(1, mk(32'hDEAD_0000), 0, 0, popped, ex, ac);
    checks++;
    if (count_o !== 4'd8) begin
      errors++;
      $display("FAIL full_push_dropped: count=%0d, required 8", count_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1, 0, popped, ex, ac);
      checks++;
      if (!popped || ac !== ex || ac.pc !== 32'h8000_0000 + 32'(4 * i)) begin
        errors++;
        $display("FAIL drain_pop%0d: pc=%h inst=%h, required pc=%h inst=%h", i, ac.pc, ac.inst, ex.pc, ex.inst);
      end
      if (i == 0) begin
        checks++;
        if (queue_ready !== 1'b1 || count_o !== 4'd7) begin
          errors++;
          $display("FAIL ready_after_pop: ready=%b count=%0d, required 1/7", queue_ready, count_o);
        end
      end
      $display("drain: pc=%h count=%0d", ac.pc, count_o);
    end
    checks++;
    if (queue_valid !== 1'b0 || count_o !== 4'd0 || pc_o !== 32'd0) begin
      errors++;
      $display("FAIL drained_empty: valid=%b count=%0d pc=%h, required 0/0/0", queue_valid, count_o, pc_o);
    end
  endtask

  task automatic test_single;
    bit popped; ent_t ex, ac, e;
    e = mk(32'h1000);
    e.inst = 32'h0000_0013;
    step(1, e, 1, 0, popped, ex, ac);
    checks++;
    if (popped || ac !== '0) begin
      errors++;
      $display("FAIL single_no_bypass: pc=%h, required 0 with no pop", ac.pc);
    end
    checks++;
    if (queue_valid !== 1'b1 || pc_o !== 32'h1000 || inst_o !== 32'h13) begin
      errors++;
      $display("FAIL single_visible: valid=%b pc=%h inst=%h, required 1/1000/13", queue_valid, pc_o, inst_o);
    end
    step(0, '0, 1, 0, popped, ex, ac);
    checks++;
    if (!popped || ac !== ex) begin
      errors++;
      $display("FAIL single_pop: pc=%h inst=%h, required pc=%h inst=%h", ac.pc, ac.inst, ex.pc, ex.inst);
    end
    $display("single: pc=%h inst=%h", ac.pc, ac.inst);
  endtask

  task automatic test_back_to_back;
    bit popped; ent_t ex, ac;
    for (int i = 0; i < 3; i++) step(1, mk(32'h4000 + 32'(4 * i)), 0, 0, popped, ex, ac);
    for (int i = 0; i < 20; i++) begin
      step(1, mk(32'h4100 + 32'(4 * i)), 1, 0, popped, ex, ac);
      checks++;
      if (!popped || ac !== ex || count_o !== 4'd3) begin
        errors++;
        $display("FAIL b2b_%0d: pc=%h count=%0d, required pc=%h count=3", i, ac.pc, count_o, ex.pc);
      end
      $display("b2b: pc=%h count=%0d", ac.pc, count_o);
    end
    while (sb.size() != 0) begin
      step(0, '0, 1, 0, popped, ex, ac);
      checks++;
      if (!popped || ac !== ex) begin
        errors++;
        $display("FAIL b2b_drain: pc=%h, required %h", ac.pc, ex.pc);
      end
    end
  endtask

  task automatic test_flush;
    bit popped; ent_t ex, ac;
    for (int i = 0; i < 5; i++) step(1, mk(32'h3000 + 32'(4 * i)), 0, 0, popped, ex, ac);
    step(1, mk(32'h2000), 1, 1, popped, ex, ac);
    checks++;
    if (count_o !== 4'd0 || queue_valid !== 1'b0 || pc_o !== 32'd0) begin
      errors++;
      $display("FAIL flush_empty: count=%0d valid=%b pc=%h, required 0/0/0", count_o, queue_valid, pc_o);
    end
    step(1, mk(32'h5000), 0, 0, popped, ex, ac);
    step(0, '0, 1, 0, popped, ex, ac);
    checks++;
    if (!popped || ac !== ex || ac.pc === 32'h2000) begin
      errors++;
      $display("FAIL flush_after: pc=%h, required %h", ac.pc, ex.pc);
    end
    $display("flush: post-flush pc=%h", ac.pc);
    // Reset mid-stream empties the queue like a flush.
    for (int i = 0; i < 4; i++) step(1, mk(32'h6000 + 32'(4 * i)), 0, 0, popped, ex, ac);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    checks++;
    if (count_o !== 4'd0 || queue_valid !== 1'b0 || queue_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: count=%0d valid=%b ready=%b, required 0/0/1", count_o, queue_valid, queue_ready);
    end
  endtask

  task automatic test_trap;
    bit popped; ent_t ex, ac, e;
    e = mk(32'h7000);
    e.trap = 1'b1;
    e.trapno = 1'b1;
    step(1, e, 0, 0, popped, ex, ac);
    step(0, '0, 1, 0, popped, ex, ac);
    checks++;
    if (!popped || ac !== ex || ac.trap !== 1'b1 || ac.trapno !== 1'b1 || ac.pc !== 32'h7000) begin
      errors++;
      $display("FAIL trap_pop: pc=%h trap=%b trapno=%b, required pc=7000 trap=1 trapno=1", ac.pc, ac.trap, ac.trapno);
    end
    $display("trap: pc=%h trap=%b trapno=%b", ac.pc, ac.trap, ac.trapno);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_single();
    test_back_to_back();
    test_flush();
    test_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
